// File: rtl/maria_dll_pkg.sv
// Shared types for the MARIA Display List List fetch engine.
// Optional shadow-entry prefetch is enabled by defining MARIA_DLL_PREFETCH_EN.
package maria_dll_pkg;

  localparam int unsigned DLL_ENTRY_BYTES = 3;

  // ST_PROMOTE is only reachable when the prefetch build is enabled.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_ACTIVE,
    ST_PROMOTE
  } dll_state_t;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_WAIT,
    LD_REQ
  } ld_state_t;

  typedef struct packed {
    logic        dli;
    logic        h16;
    logic        h8;
    logic [3:0]  offset;
    logic [15:0] dl_ptr;
  } dll_entry_t;

endpackage

// File: rtl/maria_dll_entry_loader.sv
// Runs the 3-byte request/ack sequence for one DLL entry from a start address.
// Shared by demand fetches and (with MARIA_DLL_PREFETCH_EN) shadow prefetches.
module maria_dll_entry_loader
  import maria_dll_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              byte_ack,
  output logic              done,
  output dll_entry_t        entry
);

  ld_state_t         st, st_n;
  logic [1:0]        idx, idx_n;
  logic [ADDR_W-1:0] addr_n;
  logic [6:0]        b0, b0_n;   // byte0 without its unused bit 4
  logic [7:0]        b1, b1_n;

  assign mem_req  = (st == LD_REQ);
  assign byte_ack = mem_req && mem_ack && !start && !abort;
  assign done     = byte_ack && (idx == 2'd2);
  // The final byte is taken straight off the bus so the entry lands on the ack edge.
  assign entry    = '{dli: b0[6], h16: b0[5], h8: b0[4], offset: b0[3:0],
                      dl_ptr: {b1, mem_data}};

  always_comb begin
    st_n   = st;
    idx_n  = idx;
    addr_n = mem_addr;
    b0_n   = b0;
    b1_n   = b1;
    if (start) begin
      st_n   = LD_WAIT;
      idx_n  = '0;
      addr_n = start_addr;
    end else if (abort) begin
      st_n = LD_IDLE;
    end else begin
      case (st)
        LD_WAIT: st_n = LD_REQ;
        LD_REQ: begin
          if (mem_ack) begin
            if (idx == 2'd0) b0_n = {mem_data[7:5], mem_data[3:0]};
            if (idx == 2'd1) b1_n = mem_data;
            if (idx == 2'd2) begin
              st_n = LD_IDLE;
            end else begin
              st_n   = LD_WAIT;
              idx_n  = idx + 2'd1;
              addr_n = mem_addr + ADDR_W'(1);
            end
          end
        end
        default: st_n = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st       <= LD_IDLE;
      idx      <= '0;
      mem_addr <= '0;
      b0       <= '0;
      b1       <= '0;
    end else begin
      st       <= st_n;
      idx      <= idx_n;
      mem_addr <= addr_n;
      b0       <= b0_n;
      b1       <= b1_n;
    end
  end

endmodule

// File: rtl/maria_dll_fetch.sv
// MARIA DLL walker: fetches 3-byte DLL entries and presents the current zone.
// Define MARIA_DLL_PREFETCH_EN to add a shadow entry prefetched during each zone.
module maria_dll_fetch
  import maria_dll_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dma_en,
  input  logic [ADDR_W-1:0] zp,
  input  logic              start_frame,
  input  logic              line_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              entry_valid,
  output logic [15:0]       dl_ptr,
  output logic [3:0]        zone_offset,
  output logic              dli,
  output logic              h16,
  output logic              h8,
  output logic              busy,
  output logic              late
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DLL_ENTRY_BYTES);

  dll_state_t        st, st_n;
  logic [ADDR_W-1:0] dll_addr, dll_n;
  dll_entry_t        cur, cur_n;
  logic              ev_n, late_n;

  logic              ld_start, ld_abort, ld_byte_ack, ld_done;
  logic [ADDR_W-1:0] ld_addr;
  dll_entry_t        ld_entry;

`ifdef MARIA_DLL_PREFETCH_EN
  dll_entry_t        shadow, shadow_n;
  logic              shv, shv_n;
`endif

  maria_dll_entry_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (ld_start),
    .abort     (ld_abort),
    .start_addr(ld_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .byte_ack  (ld_byte_ack),
    .done      (ld_done),
    .entry     (ld_entry)
  );

  assign busy        = mem_req;
  assign dl_ptr      = cur.dl_ptr;
  assign zone_offset = cur.offset;
  assign dli         = cur.dli;
  assign h16         = cur.h16;
  assign h8          = cur.h8;

  always_comb begin
    st_n     = st;
    dll_n    = dll_addr;
    cur_n    = cur;
    ev_n     = entry_valid;
    late_n   = late;
    ld_start = 1'b0;
    ld_abort = 1'b0;
    ld_addr  = dll_addr;
`ifdef MARIA_DLL_PREFETCH_EN
    shadow_n = shadow;
    shv_n    = shv;
`endif
    if (line_done && !entry_valid) late_n = 1'b1;

    if (!dma_en) begin
      st_n     = ST_IDLE;
      ev_n     = 1'b0;
      ld_abort = 1'b1;
`ifdef MARIA_DLL_PREFETCH_EN
      shv_n    = 1'b0;
`endif
    end else if (start_frame) begin
      st_n     = ST_FETCH0;
      dll_n    = zp;
      late_n   = 1'b0;
      ev_n     = 1'b0;
      ld_start = 1'b1;
      ld_addr  = zp;
`ifdef MARIA_DLL_PREFETCH_EN
      shv_n    = 1'b0;
`endif
    end else begin
      case (st)
        ST_FETCH0: if (ld_byte_ack) st_n = ST_FETCH1;
        ST_FETCH1: if (ld_byte_ack) st_n = ST_FETCH2;
        ST_FETCH2: begin
          if (ld_done) begin
            cur_n = ld_entry;
            ev_n  = 1'b1;
            dll_n = dll_addr + STEP;
            st_n  = ST_ACTIVE;
`ifdef MARIA_DLL_PREFETCH_EN
            ld_start = 1'b1;
            ld_addr  = dll_addr + STEP;
`endif
          end
        end
        ST_ACTIVE: begin
`ifdef MARIA_DLL_PREFETCH_EN
          if (ld_done) begin
            shadow_n = ld_entry;
            shv_n    = 1'b1;
            dll_n    = dll_addr + STEP;
          end
`endif
          if (line_done) begin
            if (cur.offset != 4'd0) begin
              cur_n.offset = cur.offset - 4'd1;
            end else begin
`ifdef MARIA_DLL_PREFETCH_EN
              // A prefetch finishing on the zone-end edge is promoted directly.
              if (shv) begin
                cur_n    = shadow;
                shv_n    = 1'b0;
                ld_start = 1'b1;
                ld_addr  = dll_addr;
              end else if (ld_done) begin
                cur_n    = ld_entry;
                shv_n    = 1'b0;
                ld_start = 1'b1;
                ld_addr  = dll_addr + STEP;
              end else begin
                ev_n = 1'b0;
                st_n = ST_PROMOTE;
              end
`else
              ev_n     = 1'b0;
              st_n     = ST_FETCH0;
              ld_start = 1'b1;
              ld_addr  = dll_addr;
`endif
            end
          end
        end
`ifdef MARIA_DLL_PREFETCH_EN
        ST_PROMOTE: begin
          if (ld_done) begin
            cur_n    = ld_entry;
            ev_n     = 1'b1;
            dll_n    = dll_addr + STEP;
            st_n     = ST_ACTIVE;
            ld_start = 1'b1;
            ld_addr  = dll_addr + STEP;
          end
        end
`endif
        default: st_n = st;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st          <= ST_IDLE;
      dll_addr    <= '0;
      cur         <= '0;
      entry_valid <= 1'b0;
      late        <= 1'b0;
`ifdef MARIA_DLL_PREFETCH_EN
      shadow      <= '0;
      shv         <= 1'b0;
`endif
    end else begin
      st          <= st_n;
      dll_addr    <= dll_n;
      cur         <= cur_n;
      entry_valid <= ev_n;
      late        <= late_n;
`ifdef MARIA_DLL_PREFETCH_EN
      shadow      <= shadow_n;
      shv         <= shv_n;
`endif
    end
  end

endmodule

// File: tb/tb_maria_dll_fetch.sv
// Scoreboard bench for maria_dll_fetch: expected reads/entries are queued by the
// stimulus and popped by a monitor on every memory handshake and new zone entry.
module tb_maria_dll_fetch;

  logic        clk_sys = 1'b0;
  logic        reset, dma_en, start_frame, line_done, mem_ack;
  logic [15:0] zp;
  logic [7:0]  mem_data;
  logic        mem_req, entry_valid, dli, h16, h8, busy, late;
  logic [15:0] mem_addr, dl_ptr;
  logic [3:0]  zone_offset;

  always #5 clk_sys = ~clk_sys;

  maria_dll_fetch #(.ADDR_W(16)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dma_en     (dma_en),
    .zp         (zp),
    .start_frame(start_frame),
    .line_done  (line_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .entry_valid(entry_valid),
    .dl_ptr     (dl_ptr),
    .zone_offset(zone_offset),
    .dli        (dli),
    .h16        (h16),
    .h8         (h8),
    .busy       (busy),
    .late       (late)
  );

  logic [7:0]  mem [logic [15:0]];
  int          stall = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_addr [$];
  logic [22:0] exp_entry [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic put(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    mem[a] = b0; mem[a1] = b1; mem[a2] = b2;
  endtask

  // Queue the three reads at a, a+1, a+2 and the entry those bytes decode to.
  task automatic expect_fetch(input logic [15:0] a);
    logic [15:0] a1, a2;
    logic [7:0]  b0;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    b0 = rd(a);
    exp_addr.push_back(a); exp_addr.push_back(a1); exp_addr.push_back(a2);
    exp_entry.push_back({b0[7:5], b0[3:0], rd(a1), rd(a2)});
  endtask

  // Zero-wait (stall=0) or stalled memory responder, ack driven just after the edge.
  always @(posedge clk_sys) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= stall) begin
        mem_ack  = 1'b1;
        mem_data = rd(mem_addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  logic        prev_valid = 1'b0;
  logic [18:0] prev_id = '0;
  always @(negedge clk_sys) begin
    if (mem_req && mem_ack) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        $display("FAIL read_addr: got unexpected read at %h expected none", mem_addr);
      end else begin
        check("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
    end
    if (entry_valid && (!prev_valid || {dli, h16, h8, dl_ptr} != prev_id)) begin
      if (exp_entry.size() == 0) begin
        n_checks++;
        $display("FAIL entry: got unexpected entry %h expected none",
                 {dli, h16, h8, zone_offset, dl_ptr});
      end else begin
        check("entry", 32'({dli, h16, h8, zone_offset, dl_ptr}), 32'(exp_entry.pop_front()));
      end
    end
    prev_valid = entry_valid;
    prev_id    = {dli, h16, h8, dl_ptr};
  end

  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic frame(input logic [15:0] a);
    zp = a;
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
  endtask

  task automatic pulse_line();
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
  endtask

  // Edges counted from the one that sampled the triggering pulse; exp_lat<0 only requires arrival.
  task automatic wait_valid(input string name, input int exp_lat);
    int cnt = 0;
    while (!entry_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    if (exp_lat >= 0) check(name, 32'(cnt), 32'(exp_lat));
    else check(name, 32'(entry_valid), 32'd1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; dma_en = 1'b1; start_frame = 1'b0; line_done = 1'b0;
    zp = '0; mem_ack = 1'b0; mem_data = '0;
    put(16'h2730, 8'h8A, 8'h12, 8'h34);
    put(16'h2733, 8'h65, 8'hAB, 8'hCD);
    put(16'hFFFE, 8'h23, 8'h56, 8'h78);
    put(16'h0001, 8'h40, 8'h9A, 8'hBC);
    put(16'h1000, 8'hC1, 8'h11, 8'h22);
    put(16'h2000, 8'h07, 8'h33, 8'h44);
    put(16'h3000, 8'h40, 8'h9A, 8'hBC);
    put(16'h3003, 8'h20, 8'h11, 8'h22);
    put(16'h3006, 8'h80, 8'h33, 8'h44);
    put(16'h3009, 8'h00, 8'h55, 8'h66);
    @(negedge clk_sys);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_bus", 32'({mem_req, busy, mem_addr}), 32'd0);
    check("reset_zone", 32'({entry_valid, dl_ptr, zone_offset, dli, h16, h8}), 32'd0);
    check("reset_late", 32'(late), 32'd0);

`ifndef MARIA_DLL_PREFETCH_EN
    // Zero-wait load: 8A,12,34 -> dl_ptr 1234, offset A, DLI only.
    expect_fetch(16'h2730);
    frame(16'h2730);
    wait_valid("t1_latency", 6);
    check("t1_dl_ptr", 32'(dl_ptr), 32'h1234);
    check("t1_offset", 32'(zone_offset), 32'hA);
    check("t1_flags", 32'({dli, h16, h8}), 32'b100);

    for (int i = 1; i <= 10; i++) begin
      pulse_line();
      check("t2_offset", 32'(zone_offset), 32'(10 - i));
    end
    expect_fetch(16'h2733);
    pulse_line();
    check("t2_valid_drop", 32'(entry_valid), 32'd0);
    wait_valid("t2_refetch_latency", 6);

    // Address wrap FFFE, FFFF, 0000 then next entry at 0001.
    expect_fetch(16'hFFFE);
    frame(16'hFFFE);
    wait_valid("t3_latency", 6);
    repeat (3) pulse_line();
    check("t3_offset0", 32'(zone_offset), 32'd0);
    expect_fetch(16'h0001);
    pulse_line();
    wait_valid("t3_next_latency", 6);

    // Restart during FETCH1 with a same-cycle ack: that ack is dropped.
    exp_addr.push_back(16'h1000);
    exp_addr.push_back(16'h1001);
    frame(16'h1000);
    cnt = 0;
    while (!(mem_ack && mem_req && mem_addr == 16'h1001) && cnt < 50) begin
      tick();
      cnt++;
    end
    check("t4_reach_fetch1", 32'(cnt < 50), 32'd1);
    expect_fetch(16'h2000);
    frame(16'h2000);
    check("t4_req_drop", 32'(mem_req), 32'd0);
    check("t4_valid_low", 32'(entry_valid), 32'd0);
    wait_valid("t4_reload_latency", 6);

    // Stalled memory: line_done during the fetch sets late, zone fields hold.
    stall = 10;
    expect_fetch(16'h2000);
    frame(16'h2000);
    repeat (3) tick();
    pulse_line();
    check("t5_late_set", 32'(late), 32'd1);
    check("t5_offset_hold", 32'(zone_offset), 32'd7);
    wait_valid("t5_stalled_load", -1);
    check("t5_late_sticky", 32'(late), 32'd1);
    stall = 0;
    expect_fetch(16'h2730);
    frame(16'h2730);
    check("t5_late_clear", 32'(late), 32'd0);
    wait_valid("t5_reload_latency", 6);

    // dma_en low abandons a fetch and nothing restarts without start_frame.
    stall = 3;
    frame(16'h2733);
    tick();
    check("dma_fetch_started", 32'(mem_req), 32'd1);
    dma_en = 1'b0;
    tick();
    check("dma_off_req", 32'({mem_req, busy, entry_valid}), 32'd0);
    dma_en = 1'b1;
    repeat (5) tick();
    check("dma_no_restart", 32'(mem_req), 32'd0);
    stall = 0;
`else
    // Back-to-back offset-0 zones: entry_valid holds, dl_ptr changes on line_done.
    expect_fetch(16'h3000);
    expect_fetch(16'h3003);
    expect_fetch(16'h3006);
    exp_addr.push_back(16'h3009);
    exp_addr.push_back(16'h300A);
    exp_addr.push_back(16'h300B);
    frame(16'h3000);
    wait_valid("t6_latency", 6);
    repeat (12) tick();
    pulse_line();
    check("t6_valid_hold1", 32'(entry_valid), 32'd1);
    check("t6_promote1", 32'(dl_ptr), 32'h1122);
    repeat (12) tick();
    pulse_line();
    check("t6_valid_hold2", 32'(entry_valid), 32'd1);
    check("t6_promote2", 32'(dl_ptr), 32'h3344);
    check("t6_late", 32'(late), 32'd0);
`endif

    repeat (12) tick();
    check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("entry_queue_empty", 32'(exp_entry.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
